// File: rtl/i2c_cond_pkg.sv
// Shared defaults for the I2C pad conditioner: filter length, SCL-low timeout
// and the helper that sizes the timeout counter.
package i2c_cond_pkg;

  localparam int FILTER_LEN_DEF     = 4;
  localparam int TIMEOUT_CYCLES_DEF = 1250000;

  // Smallest width w with 2**w > cycles, so the counter can hold TIMEOUT_CYCLES.
  function automatic int min_to_w(input int cycles);
    int w;
    w = 1;
    while ((longint'(1) << w) <= longint'(cycles)) w++;
    return w;
  endfunction

  localparam int TO_W_DEF = min_to_w(TIMEOUT_CYCLES_DEF);

endpackage

// File: rtl/i2c_line_filter.sv
// One I2C line: 2-FF synchroniser followed by a persistence filter; the
// filtered level only follows a sync level that has held FILTER_LEN cycles.
module i2c_line_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic pad,
  output logic filt
);

  logic       sync1, sync2;
  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      filt  <= 1'b1;
      cnt   <= '0;
    end else begin
      sync1 <= pad;
      sync2 <= sync1;
      if (sync2 == filt) begin
        cnt <= '0;
      end else if (cnt == 4'(FILTER_LEN - 1)) begin
        filt <= sync2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/i2c_bus_conditioner.sv
// Pad-side I2C conditioning: open-drain drive, filtered line levels,
// START/STOP detection, bus-busy tracking and an SCL-held-low timeout.
module i2c_bus_conditioner
  import i2c_cond_pkg::*;
#(
  parameter int FILTER_LEN     = FILTER_LEN_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int TO_W           = TO_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic sda_oe,
  input  logic scl_oe,
  inout  wire  sda_pad,
  inout  wire  scl_pad,
  output logic sda_in,
  output logic scl_in,
  output logic bus_busy,
  output logic start_det,
  output logic stop_det,
  output logic scl_stuck,
  input  logic stuck_clr
);

  // After reset the filters restart from 1 and must re-acquire a line that is
  // really low; that re-acquisition edge is not bus activity, so edge
  // detection stays blind until sync + filter latency has elapsed.
  localparam int BLANK = FILTER_LEN + 3;

  logic            sda_q, scl_q;
  logic [4:0]      blank_cnt;
  logic [TO_W-1:0] to_cnt;
  logic            armed, start_c, stop_c, stuck_set;

  assign sda_pad = sda_oe ? 1'b0 : 1'bz;
  assign scl_pad = scl_oe ? 1'b0 : 1'bz;

  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
    .clk(clk), .reset(reset), .pad(sda_pad), .filt(sda_in)
  );
  i2c_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
    .clk(clk), .reset(reset), .pad(scl_pad), .filt(scl_in)
  );

  assign armed     = (blank_cnt == 5'(BLANK));
  assign start_c   = armed &  sda_q & ~sda_in & scl_q & scl_in;
  assign stop_c    = armed & ~sda_q &  sda_in & scl_q & scl_in;
  assign stuck_set = ~stuck_clr & ~scl_in & (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      sda_q     <= 1'b1;
      scl_q     <= 1'b1;
      blank_cnt <= '0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
      bus_busy  <= 1'b0;
    end else begin
      sda_q     <= sda_in;
      scl_q     <= scl_in;
      if (!armed) blank_cnt <= blank_cnt + 5'd1;
      start_det <= start_c;
      stop_det  <= stop_c;
      if (stuck_set)    bus_busy <= 1'b0;
      else if (start_c) bus_busy <= 1'b1;
      else if (stop_c)  bus_busy <= 1'b0;
    end
  end

  // Saturating SCL-low counter; the clear beats a same-cycle set.
  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt    <= '0;
      scl_stuck <= 1'b0;
    end else if (stuck_clr) begin
      to_cnt    <= '0;
      scl_stuck <= 1'b0;
    end else if (scl_in) begin
      to_cnt <= '0;
    end else begin
      if (to_cnt != TO_W'(TIMEOUT_CYCLES)) to_cnt <= to_cnt + 1'b1;
      if (stuck_set) scl_stuck <= 1'b1;
    end
  end

endmodule
